// File: rtl/sum_uart_tx_if.sv
// ---------------------------------------------------------------------------
// sum_uart_tx_if -- signal bundle between the sum/latch core (master) and the
// UART transmit stage (slave).
//
// Signals:
//   uart_tx_en   master->slave  transmit request; a low-to-high transition
//                               asks for one frame
//   data_in[7:0] master->slave  byte to send (5-bit sum, zero-extended)
//   uart_txd     slave->master  serial line, idle high
//   uart_tx_busy slave->master  high while a frame is on the line
//   tx_done      slave->master  one-cycle pulse as the stop bit completes
//
// Handshake: this is an edge-requested transfer, not valid/ready. A request is
// the rising edge of uart_tx_en; it is accepted only while uart_tx_busy is low
// and the transmitter is idle, and data_in must be stable when that edge
// reaches the transmitter. An edge seen while busy is dropped, never queued.
// Completion is signalled by tx_done together with uart_tx_busy falling.
// ---------------------------------------------------------------------------
interface sum_uart_tx_if;
  logic       uart_tx_en;
  logic [7:0] data_in;
  logic       uart_txd;
  logic       uart_tx_busy;
  logic       tx_done;

  modport master (
    output uart_tx_en,
    output data_in,
    input  uart_txd,
    input  uart_tx_busy,
    input  tx_done
  );

  modport slave (
    input  uart_tx_en,
    input  data_in,
    output uart_txd,
    output uart_tx_busy,
    output tx_done
  );
endinterface

// File: rtl/sum_uart_tx.sv
// ---------------------------------------------------------------------------
// sum_uart_tx -- serial output stage of the sum/latch system. Sends the byte
// from the adder/latch core as one asynchronous UART frame (start, 8 data bits
// LSB first, optional even parity, stop) when the transmit-enable pin rises.
//
// Parameters:
//   CLK_FREQ      system clock in Hz
//   BAUD_RATE     line rate in bit/s
//   CLKS_PER_BIT  clock cycles per bit (CLK_FREQ/BAUD_RATE, minimum 2)
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   tx         sum_uart_tx_if.slave: uart_tx_en, data_in in; uart_txd,
//              uart_tx_busy, tx_done out (all outputs registered)
//   state_dbg  current FSM state encoding (IDLE=0 START=1 DATA=2 PARITY=3
//              STOP=4)
//
// Build option:
//   UART_PARITY_EN  when defined, an even-parity bit is sent between the last
//                   data bit and the stop bit (11-bit frames); otherwise 8N1.
// ---------------------------------------------------------------------------
module sum_uart_tx #(
  parameter int CLK_FREQ     = 10000000,
  parameter int BAUD_RATE    = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic          clk,
  input  logic          reset_n,
  sum_uart_tx_if.slave  tx,
  output logic [2:0]    state_dbg
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          txd;
  logic          busy;
  logic          done;
  logic          sync1;
  logic          sync2;
  logic          sync3;
  logic          start;
`ifdef UART_PARITY_EN
  logic          par;
`endif

  // sync3 is the previous synchronized level, so start is a one-cycle pulse
  // per rising edge of the pin no matter how long the pin stays high.
  assign start = sync2 & ~sync3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      txd     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync3   <= 1'b0;
`ifdef UART_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      sync1 <= tx.uart_tx_en;
      sync2 <= sync1;
      sync3 <= sync2;
      done  <= 1'b0;

      // Bit-period counter runs only while a frame is on the line.
      if (state != IDLE) begin
        cnt <= (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            state   <= START;
            txd     <= 1'b0;
            busy    <= 1'b1;
            shreg   <= tx.data_in;
            cnt     <= '0;
            bit_idx <= '0;
`ifdef UART_PARITY_EN
            par     <= ^tx.data_in;
`endif
          end
        end

        START: begin
          if (cnt == LAST_CNT) begin
            state <= DATA;
            txd   <= shreg[0];
          end
        end

        DATA: begin
          if (cnt == LAST_CNT) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              state <= PARITY;
              txd   <= par;
`else
              state <= STOP;
              txd   <= 1'b1;
`endif
            end else begin
              // shreg[0] is always the bit on the line; shift in the next one.
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              txd     <= shreg[1];
            end
          end
        end

`ifdef UART_PARITY_EN
        PARITY: begin
          if (cnt == LAST_CNT) begin
            state <= STOP;
            txd   <= 1'b1;
          end
        end
`endif

        STOP: begin
          if (cnt == LAST_CNT) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx.uart_txd     = txd;
  assign tx.uart_tx_busy = busy;
  assign tx.tx_done      = done;
  assign state_dbg       = state;

endmodule

// File: tb/tb_sum_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_sum_uart_tx -- self-checking bench for sum_uart_tx at CLKS_PER_BIT=4.
// Expected bytes are pushed to exp_q when a frame is requested and popped when
// the serial line has been decoded. Build with +define+UART_PARITY_EN to also
// exercise the parity bit.
// ---------------------------------------------------------------------------
module tb_sum_uart_tx;
  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef struct {
    logic [7:0] data;
    logic       start_bit;
    logic       par_bit;
    logic       stop_bit;
    int         glitches;
    int         early_done;
    logic       fell;
    logic       done_once;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] state_dbg;
  int         passed = 0;
  int         total = 0;
  logic [7:0] exp_q[$];

  sum_uart_tx_if bus();

  sum_uart_tx #(
    .CLK_FREQ    (40),
    .BAUD_RATE   (10),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx       (bus.slave),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / monitor tasks ----------------
  // Waits (bounded) on negedges until busy is seen high.
  task automatic wait_busy(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.uart_tx_busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called at the first negedge where busy is high; samples every cycle of
  // the frame, then the cycle after it and one more for the done pulse.
  task automatic record_frame(output frame_t f);
    logic [FRAME_BITS-1:0] bits;
    logic                  done_end;
    bits         = '0;
    f.glitches   = 0;
    f.early_done = 0;
    for (int i = 0; i < FRAME_BITS * CPB; i++) begin
      if (i % CPB == 0) bits[i / CPB] = bus.uart_txd;
      else if (bus.uart_txd !== bits[i / CPB]) f.glitches++;
      if (bus.uart_tx_busy !== 1'b1) f.glitches++;
      if (bus.tx_done !== 1'b0) f.early_done++;
      @(negedge clk);
    end
    f.fell     = (bus.uart_tx_busy === 1'b0);
    done_end   = bus.tx_done;
    @(negedge clk);
    f.done_once = (done_end === 1'b1) && (bus.tx_done === 1'b0);
    f.start_bit = bits[0];
    f.data      = bits[8:1];
    f.par_bit   = bits[9];
    f.stop_bit  = bits[FRAME_BITS-1];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.uart_tx_en = 1'($urandom_range(0, 1));
      bus.data_in    = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    total++; if (bus.uart_txd !== 1'b1) $display("FAIL rst_txd: got %b want 1", bus.uart_txd); else passed++;
    total++; if (bus.uart_tx_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.uart_tx_busy); else passed++;
    total++; if (bus.tx_done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.tx_done); else passed++;
    bus.uart_tx_en = 1'b0;
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    total++; if (bus.uart_txd !== 1'b1) $display("FAIL post_rst_txd: got %b want 1", bus.uart_txd); else passed++;
    total++; if (bus.uart_tx_busy !== 1'b0) $display("FAIL post_rst_busy: got %b want 0", bus.uart_tx_busy); else passed++;
    total++; if (bus.tx_done !== 1'b0) $display("FAIL post_rst_done: got %b want 0", bus.tx_done); else passed++;
    total++; if (state_dbg !== 3'd0) $display("FAIL post_rst_state: got %0d want 0", state_dbg); else passed++;
  endtask

  task automatic test_single_frame();
    frame_t     f;
    logic [7:0] exp;
    @(negedge clk);
    bus.data_in    = 8'h55;
    bus.uart_tx_en = 1'b1;
    exp_q.push_back(8'h55);
    @(negedge clk);  // after edge N
    @(negedge clk);  // after edge N+1
    total++; if (bus.uart_tx_busy !== 1'b0) $display("FAIL single_busy_early: got %b want 0", bus.uart_tx_busy); else passed++;
    @(negedge clk);  // after edge N+2
    total++; if (bus.uart_tx_busy !== 1'b1) $display("FAIL single_busy_rise: got %b want 1", bus.uart_tx_busy); else passed++;
    total++; if (bus.uart_txd !== 1'b0) $display("FAIL single_start_level: got %b want 0", bus.uart_txd); else passed++;
    record_frame(f);
    bus.uart_tx_en = 1'b0;
    exp = exp_q.pop_front();
    total++; if (f.data !== exp) $display("FAIL single_data: got %h want %h", f.data, exp); else passed++;
    total++; if (f.start_bit !== 1'b0) $display("FAIL single_start_bit: got %b want 0", f.start_bit); else passed++;
    total++; if (f.stop_bit !== 1'b1) $display("FAIL single_stop_bit: got %b want 1", f.stop_bit); else passed++;
    total++; if (f.glitches !== 0) $display("FAIL single_bit_timing: got %0d bad samples want 0", f.glitches); else passed++;
    total++; if (f.early_done !== 0) $display("FAIL single_early_done: got %0d want 0", f.early_done); else passed++;
    total++; if (f.fell !== 1'b1) $display("FAIL single_busy_fall_n42: got %b want 1", f.fell); else passed++;
    total++; if (f.done_once !== 1'b1) $display("FAIL single_done_pulse: got %b want 1", f.done_once); else passed++;
  endtask

  task automatic test_level_hold();
    frame_t     f;
    logic       ok;
    logic [7:0] exp;
    int         extra_busy;
    @(negedge clk);
    bus.data_in    = 8'hA3;
    bus.uart_tx_en = 1'b1;
    exp_q.push_back(8'hA3);
    wait_busy(10, ok);
    total++; if (ok !== 1'b1) $display("FAIL hold_busy_timeout: got %b want 1", ok); else passed++;
    bus.data_in = 8'hFF;
    record_frame(f);
    exp = exp_q.pop_front();
    total++; if (f.data !== exp) $display("FAIL hold_data: got %h want %h", f.data, exp); else passed++;
    total++; if (f.glitches !== 0) $display("FAIL hold_bit_timing: got %0d want 0", f.glitches); else passed++;
    extra_busy = 0;
    for (int i = 0; i < 55; i++) begin
      @(negedge clk);
      if (bus.uart_tx_busy !== 1'b0) extra_busy++;
    end
    bus.uart_tx_en = 1'b0;
    total++; if (extra_busy !== 0) $display("FAIL hold_one_frame: got %0d busy cycles want 0", extra_busy); else passed++;
  endtask

  task automatic test_ignored_start();
    frame_t     f;
    logic       ok;
    logic [7:0] exp;
    int         extra_busy;
    @(negedge clk);
    bus.data_in    = 8'h1E;
    bus.uart_tx_en = 1'b1;
    exp_q.push_back(8'h1E);
    wait_busy(10, ok);
    total++; if (ok !== 1'b1) $display("FAIL ign_busy_timeout: got %b want 1", ok); else passed++;
    fork
      record_frame(f);
      begin
        repeat (2) @(negedge clk);
        bus.uart_tx_en = 1'b0;
        repeat (10) @(negedge clk);   // inside data bit 2
        bus.uart_tx_en = 1'b1;
        repeat (6) @(negedge clk);
        bus.uart_tx_en = 1'b0;
      end
    join
    exp = exp_q.pop_front();
    total++; if (f.data !== exp) $display("FAIL ign_data: got %h want %h", f.data, exp); else passed++;
    total++; if (f.fell !== 1'b1) $display("FAIL ign_busy_fall: got %b want 1", f.fell); else passed++;
    extra_busy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.uart_tx_busy !== 1'b0) extra_busy++;
    end
    total++; if (extra_busy !== 0) $display("FAIL ign_not_queued: got %0d busy cycles want 0", extra_busy); else passed++;
    bus.data_in    = 8'h6B;
    bus.uart_tx_en = 1'b1;
    exp_q.push_back(8'h6B);
    wait_busy(10, ok);
    total++; if (ok !== 1'b1) $display("FAIL ign_second_timeout: got %b want 1", ok); else passed++;
    bus.uart_tx_en = 1'b0;
    record_frame(f);
    exp = exp_q.pop_front();
    total++; if (f.data !== exp) $display("FAIL ign_second_data: got %h want %h", f.data, exp); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    frame_t     f;
    logic       ok;
    logic [7:0] exp;
    @(negedge clk);
    bus.data_in    = 8'hC4;   // bit 3 is 0, so the line is low there
    bus.uart_tx_en = 1'b1;
    wait_busy(10, ok);
    total++; if (ok !== 1'b1) $display("FAIL mid_busy_timeout: got %b want 1", ok); else passed++;
    bus.uart_tx_en = 1'b0;
    repeat (18) @(negedge clk);   // middle of data bit 3
    total++; if (bus.uart_txd !== 1'b0) $display("FAIL mid_bit3_level: got %b want 0", bus.uart_txd); else passed++;
    #2 reset_n = 1'b0;
    #1;
    total++; if (bus.uart_txd !== 1'b1) $display("FAIL mid_rst_txd: got %b want 1", bus.uart_txd); else passed++;
    total++; if (bus.uart_tx_busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", bus.uart_tx_busy); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    bus.data_in    = 8'h5A;
    bus.uart_tx_en = 1'b1;
    exp_q.push_back(8'h5A);
    wait_busy(10, ok);
    total++; if (ok !== 1'b1) $display("FAIL mid_after_timeout: got %b want 1", ok); else passed++;
    bus.uart_tx_en = 1'b0;
    record_frame(f);
    exp = exp_q.pop_front();
    total++; if (f.data !== exp) $display("FAIL mid_after_data: got %h want %h", f.data, exp); else passed++;
    total++; if (f.stop_bit !== 1'b1) $display("FAIL mid_after_stop: got %b want 1", f.stop_bit); else passed++;
    total++; if (f.done_once !== 1'b1) $display("FAIL mid_after_done: got %b want 1", f.done_once); else passed++;
  endtask

  task automatic test_back_to_back();
    frame_t     f;
    logic       ok;
    logic [7:0] exp;
    logic [7:0] d;
    int         wait_cycles;
    for (int k = 0; k < 4; k++) begin
      d              = 8'($urandom_range(0, 255));
      bus.data_in    = d;
      bus.uart_tx_en = 1'b1;
      exp_q.push_back(d);
      wait_cycles = 0;
      ok          = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
        @(negedge clk);
        wait_cycles++;
        ok = (bus.uart_tx_busy === 1'b1);
      end
      total++; if (wait_cycles !== 3) $display("FAIL b2b_latency_%0d: got %0d cycles want 3", k, wait_cycles); else passed++;
      bus.uart_tx_en = 1'b0;
      record_frame(f);
      exp = exp_q.pop_front();
      total++; if (f.data !== exp) $display("FAIL b2b_data_%0d: got %h want %h", k, f.data, exp); else passed++;
      total++; if (f.glitches !== 0 || f.done_once !== 1'b1)
        $display("FAIL b2b_frame_%0d: got %0d bad samples done=%b want 0 / 1", k, f.glitches, f.done_once);
      else passed++;
    end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    frame_t     f;
    logic       ok;
    logic [7:0] exp;
    @(negedge clk);
    bus.data_in    = 8'h07;
    bus.uart_tx_en = 1'b1;
    exp_q.push_back(8'h07);
    wait_busy(10, ok);
    bus.uart_tx_en = 1'b0;
    record_frame(f);
    exp = exp_q.pop_front();
    total++; if (f.data !== exp) $display("FAIL par07_data: got %h want %h", f.data, exp); else passed++;
    total++; if (f.par_bit !== 1'b1) $display("FAIL par07_bit: got %b want 1", f.par_bit); else passed++;
    total++; if (f.fell !== 1'b1 || f.glitches !== 0) $display("FAIL par07_len44: got fell=%b bad=%0d want 1 / 0", f.fell, f.glitches); else passed++;
    bus.data_in    = 8'h03;
    bus.uart_tx_en = 1'b1;
    exp_q.push_back(8'h03);
    wait_busy(10, ok);
    bus.uart_tx_en = 1'b0;
    record_frame(f);
    exp = exp_q.pop_front();
    total++; if (f.data !== exp) $display("FAIL par03_data: got %h want %h", f.data, exp); else passed++;
    total++; if (f.par_bit !== 1'b0) $display("FAIL par03_bit: got %b want 0", f.par_bit); else passed++;
    total++; if (f.stop_bit !== 1'b1) $display("FAIL par03_stop: got %b want 1", f.stop_bit); else passed++;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    bus.uart_tx_en = 1'b0;
    bus.data_in    = 8'h00;
    test_reset();
    test_single_frame();
    test_level_hold();
    test_ignored_start();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    total++; if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
